// File: rtl/move_pkg.sv
// ---------------------------------------------------------------------------
// move_pkg
// Shared types for the snake direction-input path.
//   DIR_W    : width of the direction code driven to the movement FSM
//   dir_t    : direction code (0 = NONE, 1 = LEFT, 2 = RIGHT, 3 = UP, 4 = DOWN)
//   opposite : returns the reverse of a direction (NONE maps to NONE)
// ---------------------------------------------------------------------------
package move_pkg;

  localparam int DIR_W = 3;

  typedef enum logic [DIR_W-1:0] {
    DIR_NONE  = 3'd0,
    DIR_LEFT  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_UP    = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  // The snake may never reverse onto itself, so every turn has a forbidden
  // partner; NONE has no partner and reports NONE.
  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      default:   r = DIR_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Two-flop synchroniser, debounce counter and rising-edge detector for one
// raw push button.
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high; clears synchroniser, counter, level
//   button : raw asynchronous button level, active-high
//   press  : one-cycle pulse when the debounced level goes 0 -> 1
// The debounced level flips on the cycle after the disagreement counter has
// reached DEBOUNCE_CYCLES, so a clean press appears on `press` at edge
// k + 2 + DEBOUNCE_CYCLES when the button is first sampled at edge k.
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1Q, sync2Q;
  logic          levelQ, levelD;
  logic [CW-1:0] cntQ, cntD;
  logic          pressQ, pressD;

  // Count cycles where the synchronised input disagrees with the debounced
  // level; any agreement restarts the count. Once the count has reached the
  // threshold and the disagreement persists, the level flips and a press is
  // flagged if the new level is high.
  always_comb begin
    levelD = levelQ;
    cntD   = '0;
    pressD = 1'b0;
    if (sync2Q != levelQ) begin
      if (cntQ == CW'(DEBOUNCE_CYCLES)) begin
        levelD = ~levelQ;
        pressD = ~levelQ;
      end else begin
        cntD = cntQ + CW'(1);
      end
    end
  end

  // Synchroniser chain and debounce state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1Q <= 1'b0;
      sync2Q <= 1'b0;
      levelQ <= 1'b0;
      cntQ   <= '0;
      pressQ <= 1'b0;
    end else begin
      sync1Q <= button;
      sync2Q <= sync1Q;
      levelQ <= levelD;
      cntQ   <= cntD;
      pressQ <= pressD;
    end
  end

  assign press = pressQ;

endmodule

// File: rtl/move_input_queue.sv
// ---------------------------------------------------------------------------
// move_input_queue
// Debounces four direction buttons, filters illegal or redundant turns and
// buffers accepted turns in a FIFO; each game `tick` pops one turn into `out`.
//   clk, reset           : sole clock (rising edge), synchronous active-high reset
//   left/right/up/down   : raw asynchronous button levels, active-high
//   tick                 : one-cycle game-step strobe, pops the queue head
//   out                  : current direction code (dir_t)
//   q_count              : number of pending turns
//   q_full               : high when q_count == QUEUE_DEPTH
//   turned               : one-cycle pulse when out changes
//   drop                 : one-cycle pulse when a press is rejected
// ---------------------------------------------------------------------------
module move_input_queue
  import move_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int QUEUE_DEPTH     = 4,
  parameter int CNT_W           = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             up,
  input  logic             down,
  input  logic             tick,
  output logic [DIR_W-1:0] out,
  output logic [CNT_W-1:0] q_count,
  output logic             q_full,
  output logic             turned,
  output logic             drop
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic pressLeft, pressRight, pressUp, pressDown;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uLeft (
    .clk(clk), .reset(reset), .button(left), .press(pressLeft)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uRight (
    .clk(clk), .reset(reset), .button(right), .press(pressRight)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uUp (
    .clk(clk), .reset(reset), .button(up), .press(pressUp)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDown (
    .clk(clk), .reset(reset), .button(down), .press(pressDown)
  );

  dir_t             fifoQ [QUEUE_DEPTH];
  logic [PTR_W-1:0] rdPtrQ, wrPtrQ;
  logic [CNT_W-1:0] countQ, countD, countAfterPop;
  dir_t             lastQ;
  dir_t             outQ, outD;
  logic             turnedQ, turnedD;
  logic             dropQ, dropD;

  dir_t             pressDir, headDir, refDir;
  logic             pressValid, pop, push, accept;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(QUEUE_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Only one press per cycle is considered; lower-priority simultaneous
  // presses vanish without a drop pulse.
  always_comb begin
    pressValid = 1'b1;
    pressDir   = DIR_NONE;
    if (pressLeft)       pressDir = DIR_LEFT;
    else if (pressRight) pressDir = DIR_RIGHT;
    else if (pressUp)    pressDir = DIR_UP;
    else if (pressDown)  pressDir = DIR_DOWN;
    else                 pressValid = 1'b0;
  end

  // Pop happens first, then the new press is judged against the direction
  // the snake will be heading once everything ahead of it has executed:
  // the last queued turn if any remain, otherwise next cycle's `out`. Judging
  // after the pop is what lets a full queue accept a push on a tick cycle.
  always_comb begin
    headDir       = fifoQ[rdPtrQ];
    pop           = tick && (countQ != '0);
    countAfterPop = countQ - CNT_W'(pop);
    outD          = pop ? headDir : outQ;
    refDir        = (countAfterPop != '0) ? lastQ : outD;
    accept        = pressValid
                    && (pressDir != refDir)
                    && !((refDir != DIR_NONE) && (pressDir == opposite(refDir)))
                    && (countAfterPop < CNT_W'(QUEUE_DEPTH));
    push          = accept;
    countD        = countAfterPop + CNT_W'(push);
    turnedD       = pop && (headDir != outQ);
    dropD         = pressValid && !accept;
  end

  // FIFO storage, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) fifoQ[i] <= DIR_NONE;
      rdPtrQ  <= '0;
      wrPtrQ  <= '0;
      countQ  <= '0;
      lastQ   <= DIR_NONE;
      outQ    <= DIR_NONE;
      turnedQ <= 1'b0;
      dropQ   <= 1'b0;
    end else begin
      if (pop) rdPtrQ <= nextPtr(rdPtrQ);
      if (push) begin
        fifoQ[wrPtrQ] <= pressDir;
        wrPtrQ        <= nextPtr(wrPtrQ);
        lastQ         <= pressDir;
      end
      countQ  <= countD;
      outQ    <= outD;
      turnedQ <= turnedD;
      dropQ   <= dropD;
    end
  end

  assign out     = outQ;
  assign q_count = countQ;
  assign q_full  = (countQ == CNT_W'(QUEUE_DEPTH));
  assign turned  = turnedQ;
  assign drop    = dropQ;

endmodule
